// File: rtl/fir_sched_pkg.sv
// fir_sched_pkg: shared state type, width helpers and reset constants for fir_sample_scheduler
package fir_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Channel tag width: max(1, clog2(n))
    function automatic int chw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Gap counter width: max(1, clog2(g+1))
    function automatic int gapw(input int g);
        return (g < 1) ? 1 : $clog2(g + 1);
    endfunction

    localparam state_e RST_STATE = IDLE;
    localparam logic   RST_DV    = 1'b0;

endpackage

// File: rtl/fir_sample_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, search starts at last+1 and wraps modulo NCH
module rr_arbiter #(
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic [NCH-1:0] req,
    input  logic [CHW-1:0] last,
    output logic [NCH-1:0] gnt,
    output logic [CHW-1:0] idx
);

    // First requester after the previous winner takes the grant
    always_comb begin
        int c;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 1; k <= NCH; k++) begin
            c = (int'(last) + k) % NCH;
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = CHW'(c);
            end
        end
    end

endmodule

// File: rtl/fir_sample_scheduler.sv
// fir_sample_scheduler: round-robin FIFO pop scheduler feeding one shared FIR; optional FIR_SCHED_CH0_PRIO_EN gives channel 0 fixed priority
module fir_sample_scheduler
    import fir_sched_pkg::*;
#(
    parameter  int NCH = 4,
    parameter  int DW  = 8,
    parameter  int GAP = 2,
    localparam int CHW = chw(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*DW-1:0] data,
    input  logic [NCH-1:0]    avail,
    input  logic [NCH-1:0]    en,
    input  logic              fir_ready,
    output logic [NCH-1:0]    ack,
    output logic [DW-1:0]     q,
    output logic              dv,
    output logic [CHW-1:0]    ch
);

    localparam int            GW       = gapw(GAP);
    localparam logic [CHW-1:0] LAST_RST = CHW'(NCH - 1);
    localparam logic [GW-1:0]  GAP_LD   = GW'(GAP > 0 ? GAP - 1 : 0);

    state_e          state_q;
    logic [GW-1:0]   cnt_q;
    logic [CHW-1:0]  last_q;
    logic [NCH-1:0]  ack_q;
    logic [DW-1:0]   q_q;
    logic            dv_q;
    logic [CHW-1:0]  ch_q;

    logic [NCH-1:0]  req;
    logic [NCH-1:0]  arb_gnt;
    logic [CHW-1:0]  arb_idx;
    logic            p0;
    logic [NCH-1:0]  w_gnt;
    logic [CHW-1:0]  w_idx;

    assign req = avail & en;

    rr_arbiter #(
        .NCH (NCH),
        .CHW (CHW)
    ) u_arb (
        .req  (req),
        .last (last_q),
        .gnt  (arb_gnt),
        .idx  (arb_idx)
    );

`ifdef FIR_SCHED_CH0_PRIO_EN
    assign p0 = req[0];
`else
    assign p0 = 1'b0;
`endif

    // A channel-0 priority win bypasses the rotation and leaves last untouched
    always_comb begin
        w_gnt = p0 ? NCH'(1) : arb_gnt;
        w_idx = p0 ? '0 : arb_idx;
    end

    // Scheduler FSM, gap counter and registered outputs; non-issue cycles clear all outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            last_q  <= LAST_RST;
            ack_q   <= '0;
            q_q     <= '0;
            dv_q    <= RST_DV;
            ch_q    <= '0;
        end else begin
            ack_q <= '0;
            q_q   <= '0;
            dv_q  <= 1'b0;
            ch_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (fir_ready && |req) begin
                        ack_q <= w_gnt;
                        q_q   <= data[w_idx*DW +: DW];
                        dv_q  <= 1'b1;
                        ch_q  <= w_idx;
                        if (!p0)
                            last_q <= w_idx;
                        if (GAP > 0) begin
                            state_q <= HOLD;
                            cnt_q   <= GAP_LD;
                        end
                    end
                end
                HOLD: begin
                    if (cnt_q == '0)
                        state_q <= IDLE;
                    else
                        cnt_q <= cnt_q - 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack = ack_q;
    assign q   = q_q;
    assign dv  = dv_q;
    assign ch  = ch_q;

endmodule

// File: tb/tb_fir_sample_scheduler.sv
// tb_fir_sample_scheduler: directed table-driven checks of fir_sample_scheduler (GAP=2) plus a GAP=0 instance
module tb_fir_sample_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data;
    logic [3:0]  avail;
    logic [3:0]  en;
    logic        fir_ready;
    logic [3:0]  ack,  ack0;
    logic [7:0]  q,    q0;
    logic        dv,   dv0;
    logic [1:0]  ch,   ch0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_sample_scheduler #(.NCH(4), .DW(8), .GAP(2)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .data      (data),
        .avail     (avail),
        .en        (en),
        .fir_ready (fir_ready),
        .ack       (ack),
        .q         (q),
        .dv        (dv),
        .ch        (ch)
    );

    fir_sample_scheduler #(.NCH(4), .DW(8), .GAP(0)) u_g0 (
        .clk       (clk),
        .rst       (rst),
        .data      (data),
        .avail     (avail),
        .en        (en),
        .fir_ready (fir_ready),
        .ack       (ack0),
        .q         (q0),
        .dv        (dv0),
        .ch        (ch0)
    );

    typedef struct {
        logic       rst;
        logic [3:0] av;
        logic [3:0] en;
        logic       rdy;
        logic [3:0] ack;
        logic       dv;
        logic [1:0] ch;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] a, input logic [3:0] e, input logic rd,
                       input logic [3:0] k, input logic d, input logic [1:0] c);
        vec_t v;
        v.rst = r; v.av = a; v.en = e; v.rdy = rd; v.ack = k; v.dv = d; v.ch = c;
        vecs.push_back(v);
    endtask

    task automatic quiet(input int n, input logic [3:0] a, input logic [3:0] e, input logic rd);
        for (int i = 0; i < n; i++) add(1'b0, a, e, rd, 4'h0, 1'b0, 2'd0);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    function automatic logic [7:0] qexp(input logic d, input logic [1:0] c);
        return d ? 8'((32'(c) + 1) * 8'h11) : 8'h00;
    endfunction

    task automatic step(input logic r, input logic [3:0] a, input logic [3:0] e, input logic rd);
        rst = r; avail = a; en = e; fir_ready = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        data      = 32'h44332211;
        rst       = 1'b1;
        avail     = 4'h0;
        en        = 4'h0;
        fir_ready = 1'b0;

        // reset state
        add(1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0);
        add(1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0);
        // first grant right after release, next issue 3 cycles later
        add(1'b0, 4'h1, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0);
        quiet(2, 4'h1, 4'hF, 1'b1);
        add(1'b0, 4'h1, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0);
        // all channels requesting: 1,2,3,0 after last=0
        quiet(2, 4'hF, 4'hF, 1'b1);
        add(1'b0, 4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1);
        quiet(2, 4'hF, 4'hF, 1'b1);
        add(1'b0, 4'hF, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2);
        quiet(2, 4'hF, 4'hF, 1'b1);
        add(1'b0, 4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3);
        quiet(2, 4'hF, 4'hF, 1'b1);
        add(1'b0, 4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0);
        // FIR stalled for 5 cycles, then grant goes to channel after last (0)
        quiet(5, 4'hF, 4'hF, 1'b0);
        add(1'b0, 4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1);
        // channel 2 masked off
        quiet(2, 4'hF, 4'hB, 1'b1);
        add(1'b0, 4'hF, 4'hB, 1'b1, 4'h8, 1'b1, 2'd3);
        quiet(2, 4'hF, 4'hB, 1'b1);
        add(1'b0, 4'hF, 4'hB, 1'b1, 4'h1, 1'b1, 2'd0);
        quiet(2, 4'hF, 4'hB, 1'b1);
        add(1'b0, 4'hF, 4'hB, 1'b1, 4'h2, 1'b1, 2'd1);
        quiet(2, 4'hF, 4'hB, 1'b1);
        add(1'b0, 4'hF, 4'hB, 1'b1, 4'h8, 1'b1, 2'd3);
        quiet(2, 4'hF, 4'hB, 1'b1);
        add(1'b0, 4'hF, 4'hB, 1'b1, 4'h1, 1'b1, 2'd0);
        // reset mid-HOLD, then channel 0 wins first despite last=0 before reset
        add(1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0);
        add(1'b0, 4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0);
        // avail changes during HOLD ignored; no requests in IDLE gives nothing
        quiet(3, 4'h0, 4'hF, 1'b1);
        add(1'b0, 4'h2, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].av, vecs[i].en, vecs[i].rdy);
            chk("ack", i, 32'(ack), 32'(vecs[i].ack));
            chk("dv",  i, 32'(dv),  32'(vecs[i].dv));
            chk("ch",  i, 32'(ch),  32'(vecs[i].ch));
            chk("q",   i, 32'(q),   32'(qexp(vecs[i].dv, vecs[i].ch)));
        end

        // GAP=0 instance: single requester issues every cycle
        step(1'b1, 4'h4, 4'hF, 1'b1);
        chk("g0_rst_dv", 0, 32'(dv0), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'h4, 4'hF, 1'b1);
            chk("g0_dv",  i, 32'(dv0),  32'd1);
            chk("g0_ack", i, 32'(ack0), 32'h4);
            chk("g0_ch",  i, 32'(ch0),  32'd2);
            chk("g0_q",   i, 32'(q0),   32'h33);
        end
        // channels 0 and 2 requesting back-to-back, last=2
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ec;
`ifdef FIR_SCHED_CH0_PRIO_EN
            ec = 2'd0;
`else
            ec = (i % 2 == 0) ? 2'd0 : 2'd2;
`endif
            step(1'b0, 4'h5, 4'hF, 1'b1);
            chk("g0p_dv",  i, 32'(dv0),  32'd1);
            chk("g0p_ch",  i, 32'(ch0),  32'(ec));
            chk("g0p_ack", i, 32'(ack0), 32'(4'h1 << ec));
            chk("g0p_q",   i, 32'(q0),   32'(qexp(1'b1, ec)));
        end
        // stall on GAP=0 instance
        step(1'b0, 4'h5, 4'hF, 1'b0);
        chk("g0_stall_dv",  0, 32'(dv0),  32'd0);
        chk("g0_stall_ack", 0, 32'(ack0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_sample_scheduler.md
# fir_sample_scheduler

Round-robin read scheduler that shares one FIR filter datapath between NCH input sample FIFOs. Each cycle it is free, it picks one enabled channel whose FIFO holds data, pops one sample with a single-cycle ack pulse, and forwards the sample plus a channel tag to the shared FIR. A programmable idle gap after every issue lets show-ahead FIFO flags settle before the next pop. It sits between the per-channel FIFOs and the FIR core's input stage.

## Interface
- NCH, 4, number of requesting channels (2..16)
- DW, 8, sample width in bits
- GAP, 2, idle cycles forced after each issue (0..15)
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- data  in  NCH*DW  FIFO read data, channel i at bits [i*DW +: DW]
- avail  in  NCH  per-channel FIFO not-empty flag
- en  in  NCH  per-channel enable mask; disabled channels are never granted
- fir_ready  in  1  shared FIR can accept a sample this cycle
- ack  out  NCH  one-hot, one-cycle FIFO pop pulse
- q  out  DW  sample to FIR; zero whenever dv is low
- dv  out  1  q/ch valid, one-cycle pulse
- ch  out  CHW  channel tag of q, CHW = max(1, clog2(NCH)); zero when dv low

## Operation
- States: IDLE, HOLD.
- IDLE: request vector req = avail & en. If fir_ready=1 and req≠0, grant winner w; on that edge register q<=data[w], ch<=w, dv<=1, ack[w]<=1, last<=w. If GAP>0 go HOLD with gap counter loaded to GAP-1; if GAP=0 stay IDLE (back-to-back issue allowed).
- HOLD: no grant; q, ch, dv, ack driven to zero; counter decrements; when counter=0, return to IDLE on next edge.
- Round-robin: search starts at last+1, wraps modulo NCH; after reset last = NCH-1 so channel 0 has first priority.
- Inputs sampled only in IDLE; avail/en changes during HOLD are ignored until IDLE.
- fir_ready=0 in IDLE: hold, no ack, last unchanged.
- All outputs registered; every non-issue cycle clears q, ch, dv, ack.
- Reset (any state, mid-HOLD included): state=IDLE, counter=0, last=NCH-1, q=0, ch=0, dv=0, ack=0; first grant possible on the first edge after rst deasserts.

## Timing
- Latency: request visible in IDLE at edge k -> dv/ack/q high during cycle k+1.
- ack and dv always coincide, exactly one cycle wide.
- Issue period minimum GAP+1 cycles; with GAP=2 at most one sample per 3 cycles, matching show-ahead FIFO flag latency.
- Fairness: with all NCH channels continuously requesting, each is granted exactly once per NCH issues.
- Gap counter width clog2(GAP+1), minimum 1 bit.

## Configuration
- FIR_SCHED_CH0_PRIO_EN defined: channel 0, when requesting in IDLE, always wins regardless of last; last is not updated by a channel-0 grant, so rotation among other channels resumes unchanged.
- Not defined: pure round-robin across all channels as above.

## Structure
- Package fir_sched_pkg: state enumeration (IDLE, HOLD), CHW derivation function, reset value constants.
- Sub-module rr_arbiter: combinational, inputs req[NCH] and last, outputs one-hot grant and encoded index; scheduler FSM, gap counter and output registers stay in fir_sample_scheduler.

## Test plan
- Reset release, avail=4'b0001, en=4'hF, fir_ready=1, GAP=2 -> ack=0001, dv=1, q=data[7:0], ch=0 one cycle after release; next issue no earlier than 3 cycles later.
- All four channels requesting continuously, GAP=2 -> ch sequence 0,1,2,3,0 with dv every 3rd cycle, ack one-hot matching ch.
- fir_ready=0 for 5 cycles with avail=4'hF -> no ack/dv; on fir_ready=1 grant goes to channel after last.
- en=4'b1011, avail=4'hF -> channel 2 never granted; sequence 0,1,3,0.
- rst asserted during HOLD -> outputs zero next cycle; after release first grant is channel 0.
- GAP=0, only channel 2 requesting -> dv/ack high every cycle, ch=2; with FIR_SCHED_CH0_PRIO_EN and avail=4'b0101 -> channel 0 wins every issue.
